single_port_fifo_ctrl: RTL and testbench
========================================

Name: single_port_fifo_ctrl

Overview:
Sequencer that turns one single-port 32-bit RAM (one access per cycle: write or read) into a FIFO. It takes push and pop requests, arbitrates them round-robin onto the shared RAM port, and keeps write/read pointers, an occupancy count and full/empty flags. It forwards RAM read data, valid one cycle after the read is issued, as pop data. It sits between producer/consumer logic and the RAM instance.

Parameters:
ADDR_W, 4, RAM address width; DEPTH = 2^ADDR_W entries
AF_MARGIN, 2, almost-full margin (used only with SPFIFO_STATUS_EN)
AE_MARGIN, 2, almost-empty margin (used only with SPFIFO_STATUS_EN)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
push_valid  in  1  producer has a word to write
push_data  in  32  word to write
push_ready  out  1  push accepted this cycle when push_valid and push_ready are both high
pop_req  in  1  consumer requests a word
pop_ready  out  1  pop accepted (RAM read issued) this cycle when pop_req and pop_ready are both high
pop_data  out  32  read word; equals ram_dout
pop_data_valid  out  1  pop_data valid; high one cycle after the accepted pop
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  ADDR_W+1  occupancy, 0..DEPTH
ram_ena  out  1  RAM enable
ram_wea  out  1  RAM write enable (1 = write, 0 = read)
ram_din  out  32  RAM write data
ram_addr  out  ADDR_W  RAM address
ram_dout  in  32  RAM read data
ram_read_valid  in  1  RAM read-data valid

Behaviour:
- Reset (rst high at a clock edge): wr_ptr=0, rd_ptr=0, count=0, prio_wr=1, rd_pending=0.
- Reset output values: empty=1, full=0, push_ready=0, pop_ready=0, pop_data_valid=0, ram_ena=0. pop_data follows ram_dout.
- While rst is high, push_ready, pop_ready and ram_ena are forced to 0.
- Eligibility (combinational):
  - w_el = push_valid & ~full
  - r_el = pop_req & ~empty
- Grant:
  - Only one eligible: that side is granted.
  - Both eligible: the write is granted if prio_wr=1, otherwise the read.
  - After each contested cycle, prio_wr toggles to favour the loser.
  - Uncontested cycles leave prio_wr unchanged.
- push_ready = grant_wr. pop_ready = grant_rd. Both are combinational; each may depend on the other side's request.
- Write grant:
  - ram_ena=1, ram_wea=1, ram_addr=wr_ptr, ram_din=push_data.
  - Next edge: wr_ptr+1 (wraps modulo DEPTH) and count+1.
- Read grant:
  - ram_ena=1, ram_wea=0, ram_addr=rd_ptr.
  - Next edge: rd_ptr+1 (wraps) and count-1; rd_pending=1.
- No grant: ram_ena=0, ram_wea=0. ram_din and ram_addr hold their last values (don't-care).
- pop_data_valid = rd_pending & ram_read_valid. rd_pending is cleared on any cycle without a read grant.
- Read latency: request accepted in cycle N gives data in cycle N+1. Back-to-back pops give data every cycle.
- Count never increments and decrements in the same cycle (single port). count never exceeds DEPTH or goes below 0.
- Boundaries:
  - Full: push_ready=0; a pop is still granted.
  - Empty: pop_ready=0; a push is still granted.
  - Push and pop both requested while empty: push granted. The pop is granted in a later cycle once count ≥ 1.
  - Pointer wrap from DEPTH-1 to 0 is seamless; full/empty come from count, not pointer compare.
- Reset mid-operation: a read issued in the cycle before rst never produces pop_data_valid (rd_pending cleared). FIFO contents are discarded logically (count=0).
- No state machine beyond prio_wr and rd_pending. Everything else is pointer/count datapath.

Optional Feature:
SPFIFO_STATUS_EN
- Defined:
  - Adds outputs almost_full (count ≥ DEPTH-AF_MARGIN) and almost_empty (count ≤ AE_MARGIN), both registered from next-count so they are valid the same cycle as count.
  - Adds sticky outputs overflow (set by push_valid while full) and underflow (set by pop_req while empty).
  - overflow and underflow clear only on rst. All four reset to almost_empty=1, others 0.
- Undefined: these four ports and their logic are absent. Core behaviour is identical.

Test Plan (ADDR_W=4, DEPTH=16):
- Reset then idle → empty=1, count=0, ram_ena=0, pop_data_valid=0.
- Push 16 words 0x100..0x10F back-to-back → push_ready high for 16 cycles, full=1, count=16. A 17th push_valid sees push_ready=0; with SPFIFO_STATUS_EN, overflow=1.
- From full, pop 16 times back-to-back → pop_data 0x100..0x10F in order, each one cycle after its pop, then empty=1. A further pop_req gives pop_ready=0.
- Hold push_valid and pop_req high with count=8 → grants alternate W,R,W,R starting with W. count stays at 8/9, data order preserved.
- Fill 10, pop 10, push 10 more → write addresses 10..15,0..3 wrap correctly. Popped data matches the second set in order.
- Pop accepted at cycle N, rst asserted at N+1 → pop_data_valid=0 at N+1 and after, count=0, empty=1.

Source files
------------

// File: rtl/single_port_fifo_ctrl.sv
// single_port_fifo_ctrl: FIFO sequencer over one single-port 32-bit RAM.
// Push and pop requests share the single RAM port; contested cycles are
// arbitrated round-robin. Pop data is the RAM read data, qualified one
// cycle after the read is issued.
// Optional build macro SPFIFO_STATUS_EN adds almost_full / almost_empty
// (registered from next count) and sticky overflow / underflow flags.
//
// Handshake: a push transfers on a cycle where push_valid && push_ready;
// a pop is accepted (RAM read issued) on a cycle where pop_req && pop_ready,
// and its word appears on pop_data in the next cycle with pop_data_valid.
// push_ready / pop_ready are combinational and may depend on the other
// side's request, so requesters must not wait for ready before asserting.
module single_port_fifo_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [31:0]       push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_ready,
  output logic [31:0]       pop_data,
  output logic              pop_data_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [31:0]       ram_din,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       ram_dout,
  input  logic              ram_read_valid
`ifdef SPFIFO_STATUS_EN
  ,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  // Margins larger than the FIFO make the status thresholds meaningless.
  if (AF_MARGIN < 0 || AF_MARGIN > (1 << ADDR_W) ||
      AE_MARGIN < 0 || AE_MARGIN > (1 << ADDR_W)) begin : g_bad_margin
    $error("single_port_fifo_ctrl: margin out of range");
  end

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_prio_wr;
  logic              r_rd_pending;
  logic [ADDR_W-1:0] r_last_addr;
  logic [31:0]       r_last_din;

  logic              w_full;
  logic              w_empty;
  logic              w_w_el;
  logic              w_r_el;
  logic              w_contest;
  logic              w_grant_wr;
  logic              w_grant_rd;
  logic [ADDR_W:0]   w_count_next;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // Eligibility and round-robin grant; reset blocks every grant.
  assign w_w_el     = push_valid & ~w_full;
  assign w_r_el     = pop_req & ~w_empty;
  assign w_contest  = w_w_el & w_r_el;
  assign w_grant_wr = ~rst & w_w_el & (~w_r_el | r_prio_wr);
  assign w_grant_rd = ~rst & w_r_el & (~w_w_el | ~r_prio_wr);

  // Next occupancy: at most one of increment / decrement per cycle.
  always_comb begin
    w_count_next = r_count;
    if (w_grant_wr) begin
      w_count_next = r_count + {{ADDR_W{1'b0}}, 1'b1};
    end else if (w_grant_rd) begin
      w_count_next = r_count - {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  // Pointers, occupancy, arbitration priority and read-pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_prio_wr    <= 1'b1;
      r_rd_pending <= 1'b0;
    end else begin
      if (w_grant_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_grant_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count      <= w_count_next;
      if (w_contest) r_prio_wr <= ~r_prio_wr;
      r_rd_pending <= w_grant_rd;
    end
  end

  // Remember the last driven address / data so idle cycles keep them stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_addr <= '0;
      r_last_din  <= '0;
    end else if (w_grant_wr) begin
      r_last_addr <= r_wr_ptr;
      r_last_din  <= push_data;
    end else if (w_grant_rd) begin
      r_last_addr <= r_rd_ptr;
    end
  end

  assign push_ready     = w_grant_wr;
  assign pop_ready      = w_grant_rd;
  assign ram_ena        = w_grant_wr | w_grant_rd;
  assign ram_wea        = w_grant_wr;
  assign ram_addr       = w_grant_wr ? r_wr_ptr :
                          (w_grant_rd ? r_rd_ptr : r_last_addr);
  assign ram_din        = w_grant_wr ? push_data : r_last_din;
  assign pop_data       = ram_dout;
  // A read issued just before reset must never surface as valid data.
  assign pop_data_valid = r_rd_pending & ram_read_valid & ~rst;
  assign full           = w_full;
  assign empty          = w_empty;
  assign count          = r_count;

`ifdef SPFIFO_STATUS_EN
  localparam logic [ADDR_W:0] C_AF_TH = C_DEPTH - (ADDR_W+1)'(AF_MARGIN);
  localparam logic [ADDR_W:0] C_AE_TH = (ADDR_W+1)'(AE_MARGIN);

  // Status flags: thresholds from next count, sticky misuse flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      almost_full  <= (w_count_next >= C_AF_TH);
      almost_empty <= (w_count_next <= C_AE_TH);
      if (push_valid & w_full) overflow  <= 1'b1;
      if (pop_req & w_empty)   underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_single_port_fifo_ctrl.sv
// tb_single_port_fifo_ctrl: directed bench for single_port_fifo_ctrl with a
// queue-based FIFO model checked every cycle and literal spot checks.
module tb_single_port_fifo_ctrl;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic              push_valid;
  logic [31:0]       push_data;
  logic              push_ready;
  logic              pop_req;
  logic              pop_ready;
  logic [31:0]       pop_data;
  logic              pop_data_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ram_ena;
  logic              ram_wea;
  logic [31:0]       ram_din;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_dout;
  logic              ram_read_valid;
`ifdef SPFIFO_STATUS_EN
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;
`endif

  int checks   = 0;
  int failures = 0;

  single_port_fifo_ctrl #(.ADDR_W(ADDR_W), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .push_valid     (push_valid),
    .push_data      (push_data),
    .push_ready     (push_ready),
    .pop_req        (pop_req),
    .pop_ready      (pop_ready),
    .pop_data       (pop_data),
    .pop_data_valid (pop_data_valid),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .ram_ena        (ram_ena),
    .ram_wea        (ram_wea),
    .ram_din        (ram_din),
    .ram_addr       (ram_addr),
    .ram_dout       (ram_dout),
    .ram_read_valid (ram_read_valid)
`ifdef SPFIFO_STATUS_EN
    ,
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .overflow       (overflow),
    .underflow      (underflow)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- single-port RAM attached to the controller ----------------
  logic [31:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addr] <= ram_din;
    if (ram_ena && !ram_wea) ram_dout <= mem[ram_addr];
    ram_read_valid <= ram_ena && !ram_wea;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [31:0] exp_q[$];
  bit          m_prio    = 1'b1;
  bit          m_pending = 1'b0;
  logic [31:0] m_word    = '0;
  int          m_wr_addr = 0;
  int          m_rd_addr = 0;
  bit          m_ovf     = 1'b0;
  bit          m_unf     = 1'b0;

  initial begin
    int  sz;
    bit  w_el, r_el, ew, er, ev;
    @(posedge clk);
    forever begin
      @(negedge clk);
      sz   = exp_q.size();
      w_el = push_valid && (sz < DEPTH);
      r_el = pop_req && (sz > 0);
      if (rst) begin
        ew = 1'b0; er = 1'b0;
      end else if (w_el && r_el) begin
        ew = m_prio; er = !m_prio;
      end else begin
        ew = w_el; er = r_el;
      end
      check("push_ready", push_ready, ew);
      check("pop_ready",  pop_ready,  er);
      check("ram_ena",    ram_ena,    ew | er);
      if (ew | er) check("ram_wea", ram_wea, ew);
      if (ew) begin
        check("ram_addr_wr", ram_addr, m_wr_addr);
        check("ram_din",     ram_din,  push_data);
      end
      if (er) check("ram_addr_rd", ram_addr, m_rd_addr);
      check("count", count, sz);
      check("full",  full,  sz == DEPTH);
      check("empty", empty, sz == 0);
      ev = m_pending && !rst;
      check("pop_data_valid", pop_data_valid, ev);
      if (ev) check("pop_data", pop_data, m_word);
`ifdef SPFIFO_STATUS_EN
      check("almost_full",  almost_full,  sz >= DEPTH - 2);
      check("almost_empty", almost_empty, sz <= 2);
      check("overflow",     overflow,     m_ovf);
      check("underflow",    underflow,    m_unf);
`endif
      // advance model to the state after the coming edge
      if (rst) begin
        exp_q.delete();
        m_prio = 1'b1; m_pending = 1'b0;
        m_wr_addr = 0; m_rd_addr = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
        if (push_valid && sz == DEPTH) m_ovf = 1'b1;
        if (pop_req && sz == 0)        m_unf = 1'b1;
        if (ew) begin
          exp_q.push_back(push_data);
          m_wr_addr = (m_wr_addr + 1) % DEPTH;
        end
        if (er) begin
          m_word = exp_q.pop_front();
          m_rd_addr = (m_rd_addr + 1) % DEPTH;
        end
        m_pending = er;
        if (w_el && r_el) m_prio = !m_prio;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [31:0] got_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [31:0] base, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      push_valid = 1'b1;
      push_data  = base + acc;
      @(negedge clk);
      if (push_ready) acc++;
      step();
    end
    push_valid = 1'b0;
  endtask

  // n pop requests back-to-back, plus one trailing cycle to catch the last word.
  task automatic pop_n(input int n, output int acc);
    acc = 0;
    for (int i = 0; i <= n; i++) begin
      pop_req = (i < n);
      @(negedge clk);
      if (i > 0 && pop_data_valid) got_q.push_back(pop_data);
      if (i < n && pop_ready) acc++;
      step();
    end
    pop_req = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    int nw;
    rst = 1'b1; push_valid = 1'b0; pop_req = 1'b0; push_data = '0;
    step(); step();
    rst = 1'b0;

    // reset then idle
    @(negedge clk);
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 0);
    check("rst_ram_ena", ram_ena, 1'b0);
    check("rst_pop_valid", pop_data_valid, 1'b0);
    step();

    // fill 16 back-to-back, then a 17th attempt
    push_n(16, 32'h100, acc);
    check("fill_accepted", acc, 16);
    push_valid = 1'b1; push_data = 32'h1FF;
    @(negedge clk);
    check("fill_full", full, 1'b1);
    check("fill_count", count, 16);
    check("fill_17th_ready", push_ready, 1'b0);
    step();
    push_valid = 1'b0;
`ifdef SPFIFO_STATUS_EN
    @(negedge clk);
    check("overflow_set", overflow, 1'b1);
    step();
`endif

    // drain 16 back-to-back
    got_q.delete();
    pop_n(16, acc);
    check("drain_accepted", acc, 16);
    check("drain_words", got_q.size(), 16);
    for (int i = 0; i < got_q.size() && i < 16; i++)
      check("drain_data", got_q[i], 32'h100 + i);
    pop_req = 1'b1;
    @(negedge clk);
    check("drain_empty", empty, 1'b1);
    check("drain_extra_ready", pop_ready, 1'b0);
    step();
    pop_req = 1'b0;
`ifdef SPFIFO_STATUS_EN
    @(negedge clk);
    check("underflow_set", underflow, 1'b1);
    step();
`endif

    // contested cycles at count 8: grants alternate starting with write
    push_n(8, 32'h200, acc);
    nw = 0;
    for (int i = 0; i < 8; i++) begin
      push_valid = 1'b1; pop_req = 1'b1;
      push_data  = 32'h208 + nw;
      @(negedge clk);
      check("alt_grant", {push_ready, pop_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (push_ready) nw++;
      step();
    end
    push_valid = 1'b0; pop_req = 1'b0;
    @(negedge clk);
    check("alt_count", count, 8);
    step();
    got_q.delete();
    pop_n(8, acc);
    check("alt_words", got_q.size(), 8);
    for (int i = 0; i < got_q.size() && i < 8; i++)
      check("alt_data", got_q[i], 32'h204 + i);

    // pointer wrap: fill 10, pop 10, push 10 more
    rst = 1'b1; step(); rst = 1'b0;
    push_n(10, 32'h250, acc);
    pop_n(10, acc);
    for (int i = 0; i < 10; i++) begin
      push_valid = 1'b1; push_data = 32'h300 + i;
      @(negedge clk);
      check("wrap_ready", push_ready, 1'b1);
      check("wrap_addr", ram_addr, (10 + i) % 16);
      step();
    end
    push_valid = 1'b0;
    got_q.delete();
    pop_n(10, acc);
    check("wrap_words", got_q.size(), 10);
    for (int i = 0; i < got_q.size() && i < 10; i++)
      check("wrap_data", got_q[i], 32'h300 + i);

    // reset right after an accepted pop
    push_n(3, 32'h400, acc);
    pop_req = 1'b1;
    @(negedge clk);
    check("rstmid_pop_ready", pop_ready, 1'b1);
    step();
    pop_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rstmid_valid_n1", pop_data_valid, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_valid_n2", pop_data_valid, 1'b0);
    check("rstmid_count", count, 0);
    check("rstmid_empty", empty, 1'b1);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
